// File: rtl/wb_rr_arbiter_if.sv
// Request/grant bundle between Wishbone masters and the request arbiter.
// The master side drives requests and acknowledges, and the arbiter returns the registered grant.
interface wb_rr_arbiter_if #(
    parameter int PORTS = 4
);
    localparam int ENC_W = $clog2(PORTS);

    logic [PORTS-1:0] request;
    logic [PORTS-1:0] acknowledge;
    logic [PORTS-1:0] grant;
    logic             grant_valid;
    logic [ENC_W-1:0] grant_encoded;

    modport master (
        output request,
        output acknowledge,
        input  grant,
        input  grant_valid,
        input  grant_encoded
    );

    modport slave (
        input  request,
        input  acknowledge,
        output grant,
        output grant_valid,
        output grant_encoded
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Registered N-way Wishbone request arbiter that supports fixed-priority or round-robin selection.
// It can optionally hold a grant until the request drops or the transaction is acknowledged.
module wb_rr_arbiter #(
    parameter int PORTS                = 4,
    parameter int ARB_TYPE_ROUND_ROBIN = 0,
    parameter int ARB_BLOCK            = 0,
    parameter int ARB_BLOCK_ACK        = 1,
    parameter int LSB_HIGH_PRIORITY    = 0
) (
    input  logic           clk,
    input  logic           rst,
    wb_rr_arbiter_if.slave arb
);
    localparam int ENC_W = $clog2(PORTS);

    logic [PORTS-1:0] grant_q, grant_d;
    logic [PORTS-1:0] mask_q, mask_d;
    logic             valid_q, valid_d;
    logic [ENC_W-1:0] enc_q, enc_d;

    logic             holdNoAck;
    logic             holdAck;
    logic [PORTS-1:0] candidates;
    int               selIdx;

    // Returns the winning index under the tie rule; the result is don't-care for an empty vector.
    function automatic int pickIndex(input logic [PORTS-1:0] vec);
        int sel;
        sel = 0;
        if (LSB_HIGH_PRIORITY != 0) begin
            for (int i = PORTS - 1; i >= 0; i--) begin
                if (vec[i]) sel = i;
            end
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                if (vec[i]) sel = i;
            end
        end
        return sel;
    endfunction

    // Round robin falls back to the full request vector when no port remains past the last winner.
    always_comb begin
        holdNoAck  = (ARB_BLOCK != 0) && (ARB_BLOCK_ACK == 0) &&
                     ((grant_q & arb.request) != '0);
        holdAck    = (ARB_BLOCK != 0) && (ARB_BLOCK_ACK != 0) && valid_q &&
                     ((grant_q & arb.acknowledge) == '0);
        candidates = arb.request;
        if ((ARB_TYPE_ROUND_ROBIN != 0) && ((arb.request & mask_q) != '0)) begin
            candidates = arb.request & mask_q;
        end
        selIdx = pickIndex(candidates);
    end

    always_comb begin
        grant_d = grant_q;
        valid_d = valid_q;
        enc_d   = enc_q;
        mask_d  = mask_q;
        if (!(holdNoAck || holdAck)) begin
            if (arb.request != '0) begin
                valid_d = 1'b1;
                enc_d   = ENC_W'(selIdx);
                for (int j = 0; j < PORTS; j++) begin
                    grant_d[j] = (j == selIdx);
                end
                if (ARB_TYPE_ROUND_ROBIN != 0) begin
                    for (int j = 0; j < PORTS; j++) begin
                        mask_d[j] = (LSB_HIGH_PRIORITY != 0) ? (j > selIdx) : (j < selIdx);
                    end
                end
            end else begin
                grant_d = '0;
                valid_d = 1'b0;
                enc_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            enc_q   <= '0;
            mask_q  <= '0;
        end else begin
            grant_q <= grant_d;
            valid_q <= valid_d;
            enc_q   <= enc_d;
            mask_q  <= mask_d;
        end
    end

    assign arb.grant         = grant_q;
    assign arb.grant_valid   = valid_q;
    assign arb.grant_encoded = enc_q;
endmodule
